// File: rtl/mem_bus_interface.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_interface
// Description : One-at-a-time read/write bridge between the control unit and
//               main memory, with misalignment rejection and ACK timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_interface #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     MEM_BUS_INTERFACE_CLOCK_50,
    input  logic                     MEM_BUS_INTERFACE_ResetInHigh_In,
    input  logic                     MEM_BUS_INTERFACE_Req_In,
    input  logic                     MEM_BUS_INTERFACE_Write_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_INTERFACE_Addr_InBus,
    input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_INTERFACE_WrData_InBus,
    input  logic                     MEM_BUS_INTERFACE_MemAck_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_INTERFACE_MemData_InBus,
    output logic [DATAWIDTH_BUS-1:0] MEM_BUS_INTERFACE_MemAddr_OutBus,
    output logic [DATAWIDTH_BUS-1:0] MEM_BUS_INTERFACE_MemWrData_OutBus,
    output logic                     MEM_BUS_INTERFACE_MemRD_Out,
    output logic                     MEM_BUS_INTERFACE_MemWR_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_BUS_INTERFACE_RdData_OutBus,
    output logic                     MEM_BUS_INTERFACE_Busy_Out,
    output logic                     MEM_BUS_INTERFACE_Done_Out,
    output logic                     MEM_BUS_INTERFACE_Error_Out,
    output logic                     MEM_BUS_INTERFACE_ErrType_Out
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [7:0]               r_wait_cnt;
    logic [DATAWIDTH_BUS-1:0] r_addr;
    logic [DATAWIDTH_BUS-1:0] r_wr_data;
    logic                     r_write;
    logic [DATAWIDTH_BUS-1:0] r_rd_data;
    logic                     r_err_type;

    logic w_misaligned;
    logic w_timeout;

    assign w_misaligned = |MEM_BUS_INTERFACE_Addr_InBus[1:0];
    assign w_timeout    = (r_wait_cnt == c_TIMEOUT_LAST);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (MEM_BUS_INTERFACE_Req_In) begin
                    w_state_next = w_misaligned ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                // ACK on the last permitted cycle still counts as success
                if (MEM_BUS_INTERFACE_MemAck_In) begin
                    w_state_next = S_DONE;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge MEM_BUS_INTERFACE_CLOCK_50 or posedge MEM_BUS_INTERFACE_ResetInHigh_In) begin
        if (MEM_BUS_INTERFACE_ResetInHigh_In) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_write    <= 1'b0;
            r_rd_data  <= '0;
            r_err_type <= 1'b0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                S_IDLE: begin
                    if (MEM_BUS_INTERFACE_Req_In) begin
                        if (w_misaligned) begin
                            r_err_type <= 1'b1;
                        end else begin
                            r_addr     <= MEM_BUS_INTERFACE_Addr_InBus;
                            r_wr_data  <= MEM_BUS_INTERFACE_WrData_InBus;
                            r_write    <= MEM_BUS_INTERFACE_Write_In;
                            r_wait_cnt <= 8'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                    if (MEM_BUS_INTERFACE_MemAck_In) begin
                        if (!r_write) begin
                            r_rd_data <= MEM_BUS_INTERFACE_MemData_InBus;
                        end
                    end else if (w_timeout) begin
                        r_err_type <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is a decode of registered state, never of a live input
    assign MEM_BUS_INTERFACE_MemAddr_OutBus   = r_addr;
    assign MEM_BUS_INTERFACE_MemWrData_OutBus = r_wr_data;
    assign MEM_BUS_INTERFACE_MemRD_Out        = (r_state == S_ACCESS) && !r_write;
    assign MEM_BUS_INTERFACE_MemWR_Out        = (r_state == S_ACCESS) && r_write;
    assign MEM_BUS_INTERFACE_RdData_OutBus    = r_rd_data;
    assign MEM_BUS_INTERFACE_Busy_Out         = (r_state != S_IDLE);
    assign MEM_BUS_INTERFACE_Done_Out         = (r_state == S_DONE);
    assign MEM_BUS_INTERFACE_Error_Out        = (r_state == S_ERR);
    assign MEM_BUS_INTERFACE_ErrType_Out      = r_err_type;

endmodule
`default_nettype wire

// File: doc/mem_bus_interface.md
# mem_bus_interface

Bus-interface stage between the microdatapath control unit and main memory. It accepts one read or write request at a time, latches its address and write data, and drives the main-memory address, data, RD and WRMain lines. It then waits for the memory ACK, captures read data, and returns a one-cycle completion or error pulse to the control unit. Misaligned addresses are rejected locally, and a bounded wait aborts a request that memory never acknowledges.

## Interface
- DATAWIDTH_BUS, 32: width of the address and data buses.
- TIMEOUT_CYCLES, 16: maximum number of cycles spent in ACCESS without an ACK; legal range 1..255.

- MEM_BUS_INTERFACE_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- MEM_BUS_INTERFACE_ResetInHigh_In  in  1  asynchronous, active-high reset.
- MEM_BUS_INTERFACE_Req_In  in  1  request from the control unit; level, sampled only in IDLE.
- MEM_BUS_INTERFACE_Write_In  in  1  access type: 1 = write, 0 = read; sampled with Req.
- MEM_BUS_INTERFACE_Addr_InBus  in  DATAWIDTH_BUS  byte address; sampled with Req.
- MEM_BUS_INTERFACE_WrData_InBus  in  DATAWIDTH_BUS  write data; sampled with Req.
- MEM_BUS_INTERFACE_MemAck_In  in  1  ACK from main memory.
- MEM_BUS_INTERFACE_MemData_InBus  in  DATAWIDTH_BUS  read data from main memory.
- MEM_BUS_INTERFACE_MemAddr_OutBus  out  DATAWIDTH_BUS  address to main memory A bus.
- MEM_BUS_INTERFACE_MemWrData_OutBus  out  DATAWIDTH_BUS  write data to main memory B bus.
- MEM_BUS_INTERFACE_MemRD_Out  out  1  read strobe to main memory.
- MEM_BUS_INTERFACE_MemWR_Out  out  1  write strobe (WRMain) to main memory.
- MEM_BUS_INTERFACE_RdData_OutBus  out  DATAWIDTH_BUS  last successfully read word.
- MEM_BUS_INTERFACE_Busy_Out  out  1  high while a request is in flight.
- MEM_BUS_INTERFACE_Done_Out  out  1  one-cycle pulse on successful completion.
- MEM_BUS_INTERFACE_Error_Out  out  1  one-cycle pulse on an aborted request.
- MEM_BUS_INTERFACE_ErrType_Out  out  1  cause of the last error: 0 = timeout, 1 = misaligned; held until the next error.

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR. All outputs are decoded from registered state or registers only; no combinational input-to-output paths.
- IDLE
  - Busy = 0 and both strobes are low.
  - If Req = 1 and Addr[1:0] ≠ 0: set ErrType = 1 and go to ERR. No strobe is issued and the address/data registers are unchanged.
  - If Req = 1 and Addr[1:0] = 0: latch Addr, WrData and Write into registers, clear the wait counter, and go to ACCESS.
- ACCESS
  - Busy = 1.
  - MemRD = ~write flag and MemWR = write flag; the strobe is held for every ACCESS cycle.
  - MemAddr and MemWrData drive the latched values.
  - The wait counter increments by 1 each cycle.
- ACCESS exit
  - If MemAck = 1: on a read, capture MemData into RdData, then go to DONE.
  - Else if counter = TIMEOUT_CYCLES-1: set ErrType = 0 and go to ERR.
- DONE: Busy = 1, Done = 1, strobes low; go to IDLE.
- ERR: Busy = 1, Error = 1, strobes low; go to IDLE.
- RdData changes only on a successful read. Writes, timeouts and misaligned requests leave it unchanged.
- MemAddr and MemWrData hold their last latched values outside ACCESS.
- Req held high through DONE/ERR is ignored. If Req is still high on return to IDLE, a new request starts; the control unit must drop Req on Done or Error.
- MemAck is ignored outside ACCESS.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE and counter = 0.
  - All registers (address, write data, write flag, RdData, ErrType) = 0.
  - Every output = 0.
- Reset mid-ACCESS drops the strobe in the same cycle with no Done or Error pulse; the aborted request is lost.
- Request accept: Req sampled at edge E0 puts the block in ACCESS after E0; strobe and Busy are high from E0.
- Zero-wait access: MemAck high at E1 → DONE after E1. Done is high E1–E2 and RdData is valid from E1. IDLE after E2.
- Minimum request-to-request spacing: 3 cycles.
- Wait states: each extra cycle MemAck stays low adds one cycle of latency.
- Timeout: with no ACK, ERR follows the TIMEOUT_CYCLES-th ACCESS edge, i.e. the strobe is high for exactly TIMEOUT_CYCLES cycles.
- MemAck on the final permitted cycle counts as success: ACK wins over timeout.
- Misaligned request: ERR after E0, Error pulse E0–E1, IDLE after E1.

## Test plan
- Reset, then a read of Addr 0x00000010 with MemAck high on the first ACCESS cycle and MemData = 0xDEADBEEF → MemRD high for 1 cycle, Done pulse, RdData = 0xDEADBEEF, Busy low 2 cycles after the ACK.
- Write of Addr 0x00000020 with WrData 0x12345678 and MemAck delayed 3 cycles → MemWR high for 4 cycles, MemAddr = 0x20, MemWrData = 0x12345678, Done pulse, RdData unchanged.
- Read with MemAck never asserted, TIMEOUT_CYCLES = 16 → MemRD high exactly 16 cycles, Error pulse, ErrType = 0, RdData unchanged.
- MemAck asserted exactly on the 16th ACCESS cycle → Done pulse and no Error; the read data is captured.
- Read of Addr 0x00000013 → no strobe, Error pulse 1 cycle after the request, ErrType = 1, MemAddr unchanged.
- Reset asserted in the 2nd cycle of a waiting write → MemWR and Busy drop immediately and all outputs = 0. After release, a new read completes normally.
